// File: rtl/fft_controller.sv
// ---------------------------------------------------------------------------
// fft_controller
//   Sequencing FSM for a 512-point radix-2 FFT. It loads 512 natural-order
//   samples, runs N_LEVELS levels of N_BFLY butterflies over a ping-pong RAM
//   pair, then streams 512 results out with a valid/ready handshake.
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   start                one-cycle frame request (honoured in IDLE only)
//   sample_valid         input sample present (LOAD)
//   out_ready            consumer accepts current output word
//   load/processing/done phase flags (one-hot or all zero)
//   busy                 any state but IDLE
//   load_address/load_we sample write index and strobe
//   fft_level/butterfly_iter          read-side level and butterfly index
//   wr_fft_level/wr_butterfly_iter    same, delayed BFLY_LAT cycles
//   bfly_we              butterfly result write enable (delayed issue)
//   rd_bank              bank read this level (fft_level[0])
//   out_address/out_valid             output index and data-valid flag
//   frame_done           pulse on the final output handshake
// ---------------------------------------------------------------------------
module fft_controller #(
  parameter int unsigned N_LEVELS = 9,
  parameter int unsigned N_BFLY   = 256,
  parameter int unsigned BFLY_LAT = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       sample_valid,
  input  logic       out_ready,
  output logic       load,
  output logic       processing,
  output logic       done,
  output logic       busy,
  output logic [8:0] load_address,
  output logic       load_we,
  output logic [8:0] fft_level,
  output logic [8:0] butterfly_iter,
  output logic [8:0] wr_fft_level,
  output logic [8:0] wr_butterfly_iter,
  output logic       bfly_we,
  output logic       rd_bank,
  output logic [8:0] out_address,
  output logic       out_valid,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PROC,
    S_DRAIN,
    S_OUT
  } state_e;

  localparam logic [8:0] LAST_SAMPLE = 9'd511;
  localparam logic [8:0] LAST_ITER   = 9'(N_BFLY - 1);
  localparam logic [8:0] LAST_LEVEL  = 9'(N_LEVELS - 1);

  state_e              state_q;
  logic [8:0]          load_addr_q;
  logic [8:0]          level_q;
  logic [8:0]          iter_q;
  logic [8:0]          out_addr_q;
  logic                out_valid_q;

  // Issue pipeline: valid bit plus the level/iteration it was issued with.
  logic [BFLY_LAT-1:0] dly_v_q;
  logic [8:0]          dly_lvl_q [BFLY_LAT];
  logic [8:0]          dly_it_q  [BFLY_LAT];

  logic                issue;
  logic                drain_done;
  logic                out_hs;

  assign issue  = (state_q == S_PROC);
  assign out_hs = (state_q == S_OUT) && out_valid_q && out_ready;

  // The pipeline is empty after this cycle once only the final stage (which
  // writes now) can still hold a valid entry.
  always_comb begin
    drain_done = 1'b1;
    for (int unsigned i = 0; i + 1 < BFLY_LAT; i++) begin
      if (dly_v_q[i]) drain_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dly_v_q <= '0;
      for (int unsigned i = 0; i < BFLY_LAT; i++) begin
        dly_lvl_q[i] <= '0;
        dly_it_q[i]  <= '0;
      end
    end else begin
      dly_v_q[0]   <= issue;
      // Zeros shift in when not issuing so the write-side outputs read 0
      // whenever no write is pending.
      dly_lvl_q[0] <= issue ? level_q : '0;
      dly_it_q[0]  <= issue ? iter_q  : '0;
      for (int unsigned i = 1; i < BFLY_LAT; i++) begin
        dly_v_q[i]   <= dly_v_q[i-1];
        dly_lvl_q[i] <= dly_lvl_q[i-1];
        dly_it_q[i]  <= dly_it_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      load_addr_q <= '0;
      level_q     <= '0;
      iter_q      <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_LOAD;
            load_addr_q <= '0;
          end
        end

        S_LOAD: begin
          if (sample_valid) begin
            if (load_addr_q == LAST_SAMPLE) begin
              state_q     <= S_PROC;
              load_addr_q <= '0;
              level_q     <= '0;
              iter_q      <= '0;
            end else begin
              load_addr_q <= load_addr_q + 9'd1;
            end
          end
        end

        S_PROC: begin
          if (iter_q == LAST_ITER) begin
            state_q <= S_DRAIN;
          end else begin
            iter_q <= iter_q + 9'd1;
          end
        end

        S_DRAIN: begin
          if (drain_done) begin
            if (level_q == LAST_LEVEL) begin
              state_q     <= S_OUT;
              out_addr_q  <= '0;
              out_valid_q <= 1'b0;
            end else begin
              state_q <= S_PROC;
              level_q <= level_q + 9'd1;
              iter_q  <= '0;
            end
          end
        end

        S_OUT: begin
          if (out_hs) begin
            if (out_addr_q == LAST_SAMPLE) begin
              state_q     <= S_IDLE;
              load_addr_q <= '0;
              level_q     <= '0;
              iter_q      <= '0;
              out_addr_q  <= '0;
              out_valid_q <= 1'b0;
            end else begin
              out_addr_q  <= out_addr_q + 9'd1;
              out_valid_q <= 1'b0;
            end
          end else begin
            // First cycle at an address covers the synchronous RAM read.
            out_valid_q <= 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign load              = (state_q == S_LOAD);
  assign processing        = (state_q == S_PROC) || (state_q == S_DRAIN);
  assign done              = (state_q == S_OUT);
  assign busy              = (state_q != S_IDLE);
  assign load_address      = load_addr_q;
  assign load_we           = load && sample_valid;
  assign fft_level         = level_q;
  assign butterfly_iter    = iter_q;
  assign wr_fft_level      = dly_lvl_q[BFLY_LAT-1];
  assign wr_butterfly_iter = dly_it_q[BFLY_LAT-1];
  assign bfly_we           = dly_v_q[BFLY_LAT-1];
  assign rd_bank           = level_q[0];
  assign out_address       = out_addr_q;
  assign out_valid         = out_valid_q;
  assign frame_done        = out_hs && (out_addr_q == LAST_SAMPLE);

endmodule

// File: tb/tb_fft_controller.sv
// ---------------------------------------------------------------------------
// tb_fft_controller
//   Self-checking bench for fft_controller. Expected values come from a
//   cycle-schedule model: per-level cost of 256+LAT cycles, issue k written
//   LAT cycles later, one output word per handshake, and accepted-sample
//   counting during load.
// ---------------------------------------------------------------------------
module tb_fft_controller;

  localparam int LAT   = 3;
  localparam int PER   = 256 + LAT;
  localparam int TOTAL = 9 * PER;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       sample_valid;
  logic       out_ready;
  logic       load;
  logic       processing;
  logic       done;
  logic       busy;
  logic [8:0] load_address;
  logic       load_we;
  logic [8:0] fft_level;
  logic [8:0] butterfly_iter;
  logic [8:0] wr_fft_level;
  logic [8:0] wr_butterfly_iter;
  logic       bfly_we;
  logic       rd_bank;
  logic [8:0] out_address;
  logic       out_valid;
  logic       frame_done;

  logic [62:0] all_o;

  int n_tests;
  int n_fail;

  fft_controller #(
    .N_LEVELS(9),
    .N_BFLY  (256),
    .BFLY_LAT(LAT)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .sample_valid     (sample_valid),
    .out_ready        (out_ready),
    .load             (load),
    .processing       (processing),
    .done             (done),
    .busy             (busy),
    .load_address     (load_address),
    .load_we          (load_we),
    .fft_level        (fft_level),
    .butterfly_iter   (butterfly_iter),
    .wr_fft_level     (wr_fft_level),
    .wr_butterfly_iter(wr_butterfly_iter),
    .bfly_we          (bfly_we),
    .rd_bank          (rd_bank),
    .out_address      (out_address),
    .out_valid        (out_valid),
    .frame_done       (frame_done)
  );

  assign all_o = {load, processing, done, busy, load_address, load_we,
                  fft_level, butterfly_iter, wr_fft_level, wr_butterfly_iter,
                  bfly_we, rd_bank, out_address, out_valid, frame_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    reset_n = 1'b0;
    start = 1'b1;
    sample_valid = 1'b1;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (all_o !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: outputs=%h required=0", all_o);
    end
    start = 1'b0;
    sample_valid = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if (all_o !== '0) begin
        n_fail++;
        $display("FAIL idle_after_reset: cycle %0d outputs=%h required=0", i, all_o);
      end
    end
  endtask

  // mode 0: sample_valid always 1; mode 1: toggled then random gaps.
  task automatic test_load(input int mode);
    int acc;
    int cyc;
    logic sv;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc = 0;
    cyc = 0;
    while (acc < 512 && cyc < 5000) begin
      if (mode == 0) sv = 1'b1;
      else if (cyc < 64) sv = (cyc % 2 == 0);
      else sv = 1'($urandom_range(0, 1));
      sample_valid = sv;
      #1;
      n_tests++;
      if (load !== 1'b1 || processing !== 1'b0 || load_address !== 9'(acc) || load_we !== sv) begin
        n_fail++;
        $display("FAIL load_step: cyc %0d load=%b proc=%b addr=%0d we=%b required load=1 proc=0 addr=%0d we=%b",
                 cyc, load, processing, load_address, load_we, acc, sv);
      end
      if (sv) acc++;
      cyc++;
      @(negedge clk);
    end
    sample_valid = 1'b0;
    if (acc < 512) begin
      n_tests++;
      n_fail++;
      $display("FAIL load_timeout: accepted=%0d required=512", acc);
    end
    if (mode == 0) begin
      n_tests++;
      if (cyc != 512) begin
        n_fail++;
        $display("FAIL full_load_cycles: cycles=%0d required=512", cyc);
      end
    end
    #1;
    n_tests++;
    if (processing !== 1'b1 || load !== 1'b0 || load_address !== 9'd0 ||
        fft_level !== 9'd0 || butterfly_iter !== 9'd0 || load_we !== 1'b0) begin
      n_fail++;
      $display("FAIL load_to_proc: proc=%b load=%b addr=%0d lvl=%0d it=%0d we=%b required 1 0 0 0 0 0",
               processing, load, load_address, fft_level, butterfly_iter, load_we);
    end
  endtask

  // Entered at the negedge of the first PROC cycle.
  task automatic test_processing(input int start_at, input int stop_at);
    int lv;
    int r;
    int w;
    int wl;
    int wi;
    logic we_e;
    for (int c = 0; c < stop_at; c++) begin
      lv = c / PER;
      r = c % PER;
      w = c - LAT;
      we_e = 1'b0;
      wl = 0;
      wi = 0;
      if (w >= 0 && (w % PER) < 256) begin
        we_e = 1'b1;
        wl = w / PER;
        wi = w % PER;
      end
      start = (c == start_at);
      #1;
      n_tests++;
      if (processing !== 1'b1 || load !== 1'b0 || done !== 1'b0 || busy !== 1'b1 ||
          fft_level !== 9'(lv) || rd_bank !== 1'(lv % 2)) begin
        n_fail++;
        $display("FAIL proc_level: c=%0d proc=%b load=%b done=%b lvl=%0d bank=%b required proc=1 lvl=%0d bank=%0d",
                 c, processing, load, done, fft_level, rd_bank, lv, lv % 2);
      end
      if (r < 256) begin
        n_tests++;
        if (butterfly_iter !== 9'(r)) begin
          n_fail++;
          $display("FAIL proc_iter: c=%0d iter=%0d required %0d", c, butterfly_iter, r);
        end
      end
      n_tests++;
      if (bfly_we !== we_e) begin
        n_fail++;
        $display("FAIL bfly_we: c=%0d we=%b required %b", c, bfly_we, we_e);
      end
      if (we_e) begin
        n_tests++;
        if (wr_fft_level !== 9'(wl) || wr_butterfly_iter !== 9'(wi)) begin
          n_fail++;
          $display("FAIL wr_side: c=%0d wr_lvl=%0d wr_it=%0d required %0d %0d",
                   c, wr_fft_level, wr_butterfly_iter, wl, wi);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (stop_at == TOTAL) begin
      #1;
      n_tests++;
      if (processing !== 1'b0 || done !== 1'b1 || bfly_we !== 1'b0) begin
        n_fail++;
        $display("FAIL proc_to_out: proc=%b done=%b we=%b required 0 1 0", processing, done, bfly_we);
      end
    end
  endtask

  // Entered at the negedge of the first OUT cycle.
  task automatic test_output(input bit bp);
    int addr;
    int dwell;
    int stall;
    int cyc;
    bit fin;
    logic rdy;
    logic exp_v;
    logic exp_fd;
    addr = 0;
    dwell = 0;
    stall = 0;
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 4000) begin
      if (!bp) rdy = 1'b1;
      else if (addr == 100 && dwell >= 1 && stall < 10) begin
        rdy = 1'b0;
        stall++;
      end else rdy = 1'($urandom_range(0, 1));
      out_ready = rdy;
      #1;
      exp_v = (dwell > 0);
      exp_fd = exp_v && rdy && (addr == 511);
      n_tests++;
      if (done !== 1'b1 || processing !== 1'b0 || out_address !== 9'(addr) ||
          out_valid !== exp_v || frame_done !== exp_fd || bfly_we !== 1'b0) begin
        n_fail++;
        $display("FAIL out_step: cyc %0d done=%b proc=%b addr=%0d valid=%b fd=%b we=%b required done=1 addr=%0d valid=%b fd=%b",
                 cyc, done, processing, out_address, out_valid, frame_done, bfly_we, addr, exp_v, exp_fd);
      end
      if (exp_v && rdy) begin
        if (addr == 511) fin = 1'b1;
        else addr++;
        dwell = 0;
      end else begin
        dwell++;
      end
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    if (!fin) begin
      n_tests++;
      n_fail++;
      $display("FAIL out_timeout: reached address %0d", addr);
    end
    if (!bp) begin
      n_tests++;
      if (cyc != 1024) begin
        n_fail++;
        $display("FAIL out_cycles: cycles=%0d required=1024", cyc);
      end
    end
    #1;
    n_tests++;
    if (all_o !== '0) begin
      n_fail++;
      $display("FAIL out_to_idle: outputs=%h required=0", all_o);
    end
  endtask

  // Entered at the negedge of PROC cycle level 4, iteration 37.
  task automatic test_midop_reset;
    #1;
    n_tests++;
    if (fft_level !== 9'd4 || butterfly_iter !== 9'd37 || processing !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_position: lvl=%0d it=%0d proc=%b required 4 37 1",
               fft_level, butterfly_iter, processing);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (all_o !== '0) begin
      n_fail++;
      $display("FAIL midop_async_reset: outputs=%h required=0", all_o);
    end
    start = 1'b1;
    sample_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sample_valid = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (all_o !== '0) begin
        n_fail++;
        $display("FAIL post_reset_quiet: cycle %0d outputs=%h required=0", i, all_o);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    reset_n = 1'b0;
    start = 1'b0;
    sample_valid = 1'b0;
    out_ready = 1'b0;

    test_reset;

    test_load(0);
    test_processing(-1, TOTAL);
    test_output(1'b0);

    test_load(1);
    test_processing(500, TOTAL);
    test_output(1'b1);

    test_load(0);
    test_processing(-1, 4 * PER + 37);
    test_midop_reset;

    test_load(0);
    test_processing(100, TOTAL);
    test_output(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
